// File: rtl/mac_pkg.sv
// Shared definitions for the Booth MAC operand feeder.
//   DATA_W          operand width
//   FRAME_LEN_DEF   default pairs per accumulation frame
//   feeder_state_t  feeder FSM states
//   operand_pair_t  one {a, b} operand pair as stored in the FIFO
//   cnt_w()         counter width able to hold 0..n-1 (minimum 1 bit)
package mac_pkg;

    localparam int DATA_W        = 16;
    localparam int FRAME_LEN_DEF = 256;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        FLUSH
    } feeder_state_t;

    typedef struct packed {
        logic signed [DATA_W-1:0] a;
        logic signed [DATA_W-1:0] b;
    } operand_pair_t;

    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mac_operand_feeder_if.sv
// Operand feeder bus: upstream valid/ready pair input and MAC-side outputs.
//   master : upstream/driver side (drives in_valid, in_a, in_b)
//   slave  : feeder side (drives in_ready, mac_*, frame_*, fifo_level)
interface mac_operand_feeder_if
    import mac_pkg::*;
#(
    parameter int DEPTH = 8
);
    localparam int LVL_W = $clog2(DEPTH) + 1;

    logic                     in_valid;
    logic                     in_ready;
    logic signed [DATA_W-1:0] in_a;
    logic signed [DATA_W-1:0] in_b;
    logic signed [DATA_W-1:0] mac_a;
    logic signed [DATA_W-1:0] mac_b;
    logic                     mac_valid;
    logic                     frame_start;
    logic                     frame_done;
    logic [LVL_W-1:0]         fifo_level;

    modport master (
        output in_valid, in_a, in_b,
        input  in_ready, mac_a, mac_b, mac_valid, frame_start, frame_done, fifo_level
    );

    modport slave (
        input  in_valid, in_a, in_b,
        output in_ready, mac_a, mac_b, mac_valid, frame_start, frame_done, fifo_level
    );

endinterface

// File: rtl/mac_operand_fifo.sv
// Synchronous FIFO of operand pairs with registered occupancy.
//   clk, rst         clock, asynchronous active-high reset
//   push_i, wdata_i  write strobe and pair (ignored when full)
//   pop_i, rdata_o   read strobe (ignored when empty) and head-of-queue pair
//   full_o, empty_o  derived from the registered level
//   level_o          occupancy, 0..DEPTH
module mac_operand_fifo
    import mac_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push_i,
    input  operand_pair_t              wdata_i,
    input  logic                       pop_i,
    output operand_pair_t              rdata_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH):0]     level_o
);
    localparam int AW = $clog2(DEPTH);

    operand_pair_t  mem_q [DEPTH];
    logic [AW-1:0]  wr_ptr_q;
    logic [AW-1:0]  rd_ptr_q;
    logic [AW:0]    level_q;
    logic           do_push;
    logic           do_pop;

    assign full_o  = (level_q == (AW+1)'(DEPTH));
    assign empty_o = (level_q == '0);
    assign level_o = level_q;
    assign rdata_o = mem_q[rd_ptr_q];

    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    // DEPTH is a power of two, so the pointers wrap naturally.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            case ({do_push, do_pop})
                2'b10:   level_q <= level_q + (AW+1)'(1);
                2'b01:   level_q <= level_q - (AW+1)'(1);
                default: level_q <= level_q;
            endcase
        end
    end

    // Storage needs no reset; the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata_i;
    end

endmodule

// File: rtl/mac_operand_feeder.sv
// Operand feeder for the radix-8 Booth MAC. Buffers operand pairs, holds
// each on mac_a/mac_b for HOLD cycles, groups FRAME_LEN pairs into a frame
// (frame_start on the first pair) and follows each frame with FLUSH zero
// cycles (frame_done on the first of them).
//   clk, rst  clock, asynchronous active-high reset
//   feed_if   slave side of mac_operand_feeder_if (handshake in, MAC out)
module mac_operand_feeder
    import mac_pkg::*;
#(
    parameter int DEPTH     = 8,
    parameter int HOLD      = 4,
    parameter int FRAME_LEN = FRAME_LEN_DEF,
    parameter int FLUSH     = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    mac_operand_feeder_if.slave  feed_if
);
    localparam int HW = cnt_w(HOLD);
    localparam int FW = cnt_w(FLUSH);
    localparam logic [HW-1:0] HOLD_LOAD  = HW'(HOLD - 1);
    localparam logic [FW-1:0] FLUSH_LOAD = FW'(FLUSH - 1);
    localparam logic [8:0]    PAIR_LAST  = 9'(FRAME_LEN - 1);

    feeder_state_t  state_q, state_d;
    logic [HW-1:0]  hold_q, hold_d;
    logic [FW-1:0]  flush_q, flush_d;
    logic [8:0]     pair_q, pair_d;
    operand_pair_t  out_q, out_d;
    logic           valid_q, valid_d;
    logic           start_q, start_d;
    logic           done_q, done_d;
    // Keeps in_ready low while in reset and for the first edge after release.
    logic           rdy_en_q;

    logic           push, pop;
    operand_pair_t  wdata, rdata;
    logic           full, empty;
    logic [$clog2(DEPTH):0] level;

    assign wdata.a = feed_if.in_a;
    assign wdata.b = feed_if.in_b;
    assign feed_if.in_ready = rdy_en_q && !full;
    assign push = feed_if.in_valid && feed_if.in_ready;

    mac_operand_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push),
        .wdata_i (wdata),
        .pop_i   (pop),
        .rdata_o (rdata),
        .full_o  (full),
        .empty_o (empty),
        .level_o (level)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            hold_q   <= '0;
            flush_q  <= '0;
            pair_q   <= '0;
            out_q    <= '0;
            valid_q  <= 1'b0;
            start_q  <= 1'b0;
            done_q   <= 1'b0;
            rdy_en_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            hold_q   <= hold_d;
            flush_q  <= flush_d;
            pair_q   <= pair_d;
            out_q    <= out_d;
            valid_q  <= valid_d;
            start_q  <= start_d;
            done_q   <= done_d;
            rdy_en_q <= 1'b1;
        end
    end

    // FLUSH is both a parameter and a state name here, so the state literal
    // is package-qualified.
    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        flush_d = flush_q;
        pair_d  = pair_q;
        out_d   = out_q;
        valid_d = valid_q;
        start_d = 1'b0;
        done_d  = 1'b0;
        pop     = 1'b0;
        case (state_q)
            IDLE: begin
                out_d   = '0;
                valid_d = 1'b0;
                if (!empty) begin
                    pop     = 1'b1;
                    out_d   = rdata;
                    valid_d = 1'b1;
                    start_d = 1'b1;
                    pair_d  = '0;
                    hold_d  = HOLD_LOAD;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (hold_q != '0) begin
                    hold_d = hold_q - HW'(1);
                end else if (pair_q == PAIR_LAST) begin
                    flush_d = FLUSH_LOAD;
                    out_d   = '0;
                    valid_d = 1'b0;
                    done_d  = 1'b1;
                    state_d = mac_pkg::FLUSH;
                end else if (!empty) begin
                    pop     = 1'b1;
                    out_d   = rdata;
                    valid_d = 1'b1;
                    pair_d  = pair_q + 9'd1;
                    hold_d  = HOLD_LOAD;
                end else begin
                    valid_d = 1'b0;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                // Last pair stays on the bus; only mac_valid drops.
                if (!empty) begin
                    pop     = 1'b1;
                    out_d   = rdata;
                    valid_d = 1'b1;
                    pair_d  = pair_q + 9'd1;
                    hold_d  = HOLD_LOAD;
                    state_d = ISSUE;
                end
            end
            mac_pkg::FLUSH: begin
                out_d   = '0;
                valid_d = 1'b0;
                if (flush_q != '0) flush_d = flush_q - FW'(1);
                else               state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign feed_if.mac_a       = out_q.a;
    assign feed_if.mac_b       = out_q.b;
    assign feed_if.mac_valid   = valid_q;
    assign feed_if.frame_start = start_q;
    assign feed_if.frame_done  = done_q;
    assign feed_if.fifo_level  = level;

endmodule

// File: tb/tb_mac_operand_feeder.sv
// Bench for mac_operand_feeder. dut0: DEPTH 8, HOLD 4, FRAME_LEN 256,
// FLUSH 4. dut1: DEPTH 8, HOLD 2, FRAME_LEN 4, FLUSH 3 (short frames).
module tb_mac_operand_feeder;
    import mac_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    mac_operand_feeder_if #(.DEPTH(8)) if0 ();
    mac_operand_feeder_if #(.DEPTH(8)) if1 ();

    mac_operand_feeder #(.DEPTH(8), .HOLD(4), .FRAME_LEN(256), .FLUSH(4)) u_dut0 (
        .clk(clk), .rst(rst), .feed_if(if0));
    mac_operand_feeder #(.DEPTH(8), .HOLD(2), .FRAME_LEN(4), .FLUSH(3)) u_dut1 (
        .clk(clk), .rst(rst), .feed_if(if1));

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // One row per cycle on dut1: stimulus driven before the next edge,
    // expected outputs as seen after the current edge.
    typedef struct {
        logic        vld;
        logic [15:0] a, b;
        logic        ev, es, ed;
        logic [15:0] ea, eb;
        logic [3:0]  el;
    } row_t;
    row_t rows[$];

    function automatic row_t mk(input logic vld, input logic [15:0] a, input logic [15:0] b,
                                input logic ev, input logic es, input logic ed,
                                input logic [15:0] ea, input logic [15:0] eb, input logic [3:0] el);
        row_t r;
        r.vld = vld; r.a = a; r.b = b;
        r.ev = ev; r.es = es; r.ed = ed; r.ea = ea; r.eb = eb; r.el = el;
        return r;
    endfunction

    // Push one pair into dut0, honouring in_ready, bounded wait.
    task automatic push0(input logic [15:0] a, input logic [15:0] b);
        logic r;
        int   t;
        if0.in_valid = 1'b1;
        if0.in_a = a;
        if0.in_b = b;
        t = 0;
        forever begin
            @(negedge clk);
            r = if0.in_ready;
            @(posedge clk);
            #1;
            if (r) break;
            t++;
            if (t > 50) begin
                chk("push_timeout", 1, 0);
                break;
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] seq_a [14];
        logic        full_seen;
        logic        prev_v;
        logic [31:0] prev_ab;
        int          run, k;

        if0.in_valid = 1'b0; if0.in_a = '0; if0.in_b = '0;
        if1.in_valid = 1'b0; if1.in_a = '0; if1.in_b = '0;

        // Full frame on dut1 with extreme operands:
        // p0=(-32768,-32768) p1=(32767,-32768) p2=(0,0) p3=(3,-5)
        rows.push_back(mk(1, 16'h8000, 16'h8000, 0, 0, 0, 16'h0000, 16'h0000, 4'd0));
        rows.push_back(mk(1, 16'h7FFF, 16'h8000, 0, 0, 0, 16'h0000, 16'h0000, 4'd1));
        rows.push_back(mk(1, 16'h0000, 16'h0000, 1, 1, 0, 16'h8000, 16'h8000, 4'd1));
        rows.push_back(mk(1, 16'h0003, 16'hFFFB, 1, 0, 0, 16'h8000, 16'h8000, 4'd2));
        rows.push_back(mk(0, 16'h0000, 16'h0000, 1, 0, 0, 16'h7FFF, 16'h8000, 4'd2));
        rows.push_back(mk(0, 16'h0000, 16'h0000, 1, 0, 0, 16'h7FFF, 16'h8000, 4'd2));
        rows.push_back(mk(0, 16'h0000, 16'h0000, 1, 0, 0, 16'h0000, 16'h0000, 4'd1));
        rows.push_back(mk(0, 16'h0000, 16'h0000, 1, 0, 0, 16'h0000, 16'h0000, 4'd1));
        rows.push_back(mk(0, 16'h0000, 16'h0000, 1, 0, 0, 16'h0003, 16'hFFFB, 4'd0));
        rows.push_back(mk(0, 16'h0000, 16'h0000, 1, 0, 0, 16'h0003, 16'hFFFB, 4'd0));
        rows.push_back(mk(0, 16'h0000, 16'h0000, 0, 0, 1, 16'h0000, 16'h0000, 4'd0));
        rows.push_back(mk(0, 16'h0000, 16'h0000, 0, 0, 0, 16'h0000, 16'h0000, 4'd0));
        rows.push_back(mk(0, 16'h0000, 16'h0000, 0, 0, 0, 16'h0000, 16'h0000, 4'd0));
        rows.push_back(mk(0, 16'h0000, 16'h0000, 0, 0, 0, 16'h0000, 16'h0000, 4'd0));
        // Stall on dut1: A=(11,1) B=(22,2), 5 idle edges, C=(33,3) D=(44,4).
        rows.push_back(mk(1, 16'd11, 16'd1, 0, 0, 0, 16'd0,  16'd0, 4'd0));
        rows.push_back(mk(1, 16'd22, 16'd2, 0, 0, 0, 16'd0,  16'd0, 4'd1));
        rows.push_back(mk(0, 16'd0,  16'd0, 1, 1, 0, 16'd11, 16'd1, 4'd1));
        rows.push_back(mk(0, 16'd0,  16'd0, 1, 0, 0, 16'd11, 16'd1, 4'd1));
        rows.push_back(mk(0, 16'd0,  16'd0, 1, 0, 0, 16'd22, 16'd2, 4'd0));
        rows.push_back(mk(0, 16'd0,  16'd0, 1, 0, 0, 16'd22, 16'd2, 4'd0));
        rows.push_back(mk(0, 16'd0,  16'd0, 0, 0, 0, 16'd22, 16'd2, 4'd0));
        rows.push_back(mk(1, 16'd33, 16'd3, 0, 0, 0, 16'd22, 16'd2, 4'd0));
        rows.push_back(mk(1, 16'd44, 16'd4, 0, 0, 0, 16'd22, 16'd2, 4'd1));
        rows.push_back(mk(0, 16'd0,  16'd0, 1, 0, 0, 16'd33, 16'd3, 4'd1));
        rows.push_back(mk(0, 16'd0,  16'd0, 1, 0, 0, 16'd33, 16'd3, 4'd1));
        rows.push_back(mk(0, 16'd0,  16'd0, 1, 0, 0, 16'd44, 16'd4, 4'd0));
        rows.push_back(mk(0, 16'd0,  16'd0, 1, 0, 0, 16'd44, 16'd4, 4'd0));
        rows.push_back(mk(0, 16'd0,  16'd0, 0, 0, 1, 16'd0,  16'd0, 4'd0));
        rows.push_back(mk(0, 16'd0,  16'd0, 0, 0, 0, 16'd0,  16'd0, 4'd0));

        // Power-on reset.
        #1 rst = 1'b1;
        #2;
        chk("por_dut0", {if0.mac_valid, if0.frame_start, if0.frame_done, if0.in_ready,
                         if0.mac_a, if0.mac_b, if0.fifo_level}, 64'd0);
        chk("por_dut1", {if1.mac_valid, if1.frame_start, if1.frame_done, if1.in_ready,
                         if1.mac_a, if1.mac_b, if1.fifo_level}, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("por_ready0", if0.in_ready, 1);
        chk("por_ready1", if1.in_ready, 1);

        // Table: full frame then stall/resume on dut1.
        for (int i = 0; i < rows.size(); i++) begin
            if1.in_valid = rows[i].vld;
            if1.in_a     = rows[i].a;
            if1.in_b     = rows[i].b;
            @(negedge clk);
            chk($sformatf("row%0d", i),
                {if1.mac_valid, if1.frame_start, if1.frame_done, if1.mac_a, if1.mac_b, if1.fifo_level},
                {rows[i].ev, rows[i].es, rows[i].ed, rows[i].ea, rows[i].eb, rows[i].el});
            @(posedge clk);
            #1;
        end
        if1.in_valid = 1'b0;

        // Single pair on dut0: held HOLD=4 cycles, then WAIT.
        push0(16'd3, 16'hFFFB);
        if0.in_valid = 1'b0;
        @(negedge clk);
        chk("single_pushed", {if0.mac_valid, if0.fifo_level}, {1'b0, 4'd1});
        @(negedge clk);
        chk("single_first", {if0.mac_valid, if0.frame_start, if0.mac_a, if0.mac_b},
            {1'b1, 1'b1, 16'd3, 16'hFFFB});
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk($sformatf("single_hold%0d", i),
                {if0.mac_valid, if0.frame_start, if0.mac_a, if0.mac_b},
                {1'b1, 1'b0, 16'd3, 16'hFFFB});
        end
        @(negedge clk);
        chk("single_wait", {if0.mac_valid, if0.frame_start, if0.mac_a, if0.mac_b},
            {1'b0, 1'b0, 16'd3, 16'hFFFB});
        @(posedge clk);
        #1;

        // Backpressure on dut0: 14 pairs pushed as fast as in_ready allows.
        for (int i = 0; i < 14; i++) seq_a[i] = 16'(1000 + i);
        full_seen = 1'b0;
        prev_v = 1'b0;
        prev_ab = '0;
        run = 0;
        k = 0;
        fork
            begin
                for (int i = 0; i < 14; i++) push0(seq_a[i], 16'(i));
                if0.in_valid = 1'b0;
            end
            begin
                for (int c = 0; c < 80; c++) begin
                    @(negedge clk);
                    chk("bp_ready", if0.in_ready, (if0.fifo_level != 4'd8));
                    if (if0.fifo_level == 4'd8) full_seen = 1'b1;
                    if (if0.mac_valid) begin
                        if (prev_v && run < 4) begin
                            chk("bp_stable", {if0.mac_a, if0.mac_b}, prev_ab);
                            run++;
                        end else begin
                            if (k < 14) chk($sformatf("bp_order%0d", k),
                                            {if0.mac_a, if0.mac_b}, {seq_a[k], 16'(k)});
                            else chk("bp_extra_pair", 1, 0);
                            k++;
                            run = 1;
                        end
                    end
                    prev_v  = if0.mac_valid;
                    prev_ab = {if0.mac_a, if0.mac_b};
                end
            end
        join
        chk("bp_count", k, 14);
        chk("bp_full_seen", full_seen, 1);
        @(posedge clk);
        #1;

        // Reset mid-ISSUE on dut0 with one pair still queued.
        push0(16'd7, 16'd7);
        push0(16'd8, 16'd8);
        if0.in_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("rst_outputs", {if0.mac_valid, if0.frame_start, if0.frame_done, if0.mac_a, if0.mac_b},
            {3'b000, 32'd0});
        chk("rst_ready", if0.in_ready, 0);
        chk("rst_level", if0.fifo_level, 0);
        @(posedge clk);
        #1;
        chk("rst_ready_held", if0.in_ready, 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_ready_release", if0.in_ready, 0);
        @(posedge clk);
        #1;
        chk("rst_ready_after", if0.in_ready, 1);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk($sformatf("rst_idle%0d", i),
                {if0.mac_valid, if0.frame_start, if0.frame_done, if0.fifo_level}, 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
